// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: operator codes, display
// limits, the error code and the controller state encoding.
package calc_pkg;

  // Operator codes as presented on the keypad interface; 6 and 7 are invalid.
  localparam logic [2:0] EQU   = 3'd0;
  localparam logic [2:0] TIMES = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] PLUS  = 3'd3;
  localparam logic [2:0] MINUS = 3'd4;
  localparam logic [2:0] MOD   = 3'd5;

  // Display limits and the value shown on any error.
  localparam int          MAX_POS  = 999_999;
  localparam int          MIN_NEG  = -99_999;
  localparam logic [31:0] ERR_CODE = 32'h00EE_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADDSUB,
    ST_ITER,
    ST_SIGN,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Operators that run on the shared iterative multiply/divide unit.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == TIMES) || (op == DIV) || (op == MOD);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Shared unsigned iterative datapath: shift-add multiply or restoring divide,
// one step per clock. Operands are magnitudes; signs are handled by the caller.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic               sw_clk,
  input  logic               load,
  input  logic               step,
  input  logic               mode_div,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   divisor_q;

  // Partial remainder shifted left by one with the next dividend bit, and the
  // trial subtraction; the top bit of diff is the borrow (trial failed).
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, divisor_q};

  // Load fresh magnitudes, or advance the selected algorithm by one bit.
  // NOTE: pure datapath registers carry no reset; load always initialises them before any step.
  always_ff @(posedge sw_clk) begin
    if (load) begin
      prod_q    <= '0;
      mcand_q   <= {{WIDTH{1'b0}}, mag_a};
      mplier_q  <= mag_b;
      quo_q     <= mag_a;
      rem_q     <= '0;
      divisor_q <= mag_b;
    end else if (step) begin
      if (mode_div) begin
        if (diff[WIDTH]) begin
          rem_q <= rem_shift[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_q <= diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        if (mplier_q[0]) begin
          prod_q <= prod_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end

  assign product   = prod_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle calculator controller: latches a request, runs it on the adder
// or the shared iterative multiply/divide unit, range-checks the signed result
// against the display limits and presents ans/err with a one-cycle done pulse.
module calc_sequencer #(
  parameter int               WIDTH    = 32,
  parameter int               ITER     = 32,  // iteration count, must equal WIDTH
  parameter int               MAX_POS  = calc_pkg::MAX_POS,
  parameter int               MIN_NEG  = calc_pkg::MIN_NEG,
  parameter logic [WIDTH-1:0] ERR_CODE = calc_pkg::ERR_CODE
) (
  input  logic             sw_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [2:0]       operator,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] ans
);
  import calc_pkg::*;

  localparam int XW = 2 * WIDTH;
  localparam int CW = $clog2(ITER);
  localparam logic signed [XW-1:0] MAX_X = XW'(MAX_POS);
  localparam logic signed [XW-1:0] MIN_X = XW'(MIN_NEG);

  state_t                 state;
  logic [WIDTH-1:0]       op1_q;
  logic [WIDTH-1:0]       op2_q;
  logic [2:0]             opr_q;
  logic                   err_forced;
  logic signed [XW-1:0]   result_q;
  logic [CW-1:0]          cnt;

  logic                   s1;
  logic                   s2;
  logic signed [XW-1:0]   op1_x;
  logic signed [XW-1:0]   op2_x;
  logic [WIDTH-1:0]       mag1;
  logic [WIDTH-1:0]       mag2;
  logic [XW-1:0]          product;
  logic [WIDTH-1:0]       quotient;
  logic [WIDTH-1:0]       remainder;
  logic signed [XW-1:0]   addsub_val;
  logic signed [XW-1:0]   signed_val;
  logic                   err_next;

  assign s1    = op1_q[WIDTH-1];
  assign s2    = op2_q[WIDTH-1];
  assign op1_x = {{WIDTH{s1}}, op1_q};
  assign op2_x = {{WIDTH{s2}}, op2_q};

  // Magnitudes read as unsigned, so the most negative operand maps to 2^(WIDTH-1).
  assign mag1 = s1 ? (~op1_q + 1'b1) : op1_q;
  assign mag2 = s2 ? (~op2_q + 1'b1) : op2_q;

  iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .sw_clk    (sw_clk),
    .load      ((state == ST_LOAD) && is_muldiv(opr_q)),
    .step      (state == ST_ITER),
    .mode_div  (opr_q != TIMES),
    .mag_a     (mag1),
    .mag_b     (mag2),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Wide add/sub result and sign-restored multiply/divide result.
  always_comb begin
    // NOTE: every value assigned here gets a default first, so no path through the case infers a latch.
    addsub_val = op1_x;
    signed_val = product;
    case (opr_q)
      PLUS:  addsub_val = op1_x + op2_x;
      MINUS: addsub_val = op1_x - op2_x;
      TIMES: if (s1 ^ s2) signed_val = -product;
      DIV:   signed_val = (s1 ^ s2) ? -{{WIDTH{1'b0}}, quotient} : {{WIDTH{1'b0}}, quotient};
      MOD:   signed_val = s1 ? -{{WIDTH{1'b0}}, remainder} : {{WIDTH{1'b0}}, remainder};
      default: ;
    endcase
  end

  assign err_next = err_forced || (result_q > MAX_X) || (result_q < MIN_X);

  // Controller FSM with registered outputs and synchronous active-low reset.
  // NOTE: all sequential state uses <= so every register sees the values from before the edge.
  always_ff @(posedge sw_clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      ans   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op1_q <= operand1;
            op2_q <= operand2;
            opr_q <= operator;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Forced errors still pass through ADDSUB so every short path has
          // the same three-edge latency; CHECK overrides the sum.
          err_forced <= 1'b0;
          if (opr_q > MOD) begin
            err_forced <= 1'b1;
            state      <= ST_ADDSUB;
          end else if (((opr_q == DIV) || (opr_q == MOD)) && (op2_q == '0)) begin
            err_forced <= 1'b1;
            state      <= ST_ADDSUB;
          end else if (is_muldiv(opr_q)) begin
            cnt   <= '0;
            state <= ST_ITER;
          end else begin
            state <= ST_ADDSUB;
          end
        end
        ST_ADDSUB: begin
          result_q <= addsub_val;
          state    <= ST_CHECK;
        end
        ST_ITER: begin
          if (cnt == CW'(ITER - 1)) begin
            state <= ST_SIGN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SIGN: begin
          result_q <= signed_val;
          state    <= ST_CHECK;
        end
        ST_CHECK: begin
          err   <= err_next;
          ans   <= err_next ? ERR_CODE : result_q[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
